// File: rtl/block_check_sched.sv
// Round-robin scheduler sharing one begin/end nesting checker among N_CH byte sources.
// Optional idle timeout per message: define BLOCK_CHECK_SCHED_TIMEOUT_EN.
module block_check_sched #(
  parameter int          N_CH    = 4,
  parameter logic [7:0]  TERM    = 8'h0A,
  parameter int          TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     req,
  input  logic [8*N_CH-1:0]   in_char,
  input  logic [N_CH-1:0]     in_valid,
  output logic [N_CH-1:0]     in_ready,
  output logic                chk_reset,
  output logic                chk_en,
  output logic [7:0]          chk_in,
  input  logic                chk_result,
  output logic                busy,
  output logic                res_valid,
  output logic [2:0]          res_chan,
  output logic                res_ok,
  output logic                res_abort
);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, SETTLE, REPORT} state_t;

  state_t            state;
  logic [2:0]        grant;
  logic [2:0]        rr_ptr;
  logic [2:0]        next_grant;
  logic              any_req;
  logic [3:0]        pos;
  logic [N_CH-1:0]   grant_mask;
  logic [7:0]        cur_char;
  logic              cur_valid;
  logic              is_term;
  logic              timed_out;
  logic              abort_pend;

  if (N_CH < 2 || N_CH > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("block_check_sched: N_CH must be 2..8 and TIMEOUT 1..255");
  end

  // First requester at or above rr_ptr, wrapping modulo N_CH.
  always_comb begin
    any_req    = 1'b0;
    next_grant = '0;
    pos        = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pos = 4'(rr_ptr) + 4'(i);
      if (pos >= 4'(N_CH)) pos = pos - 4'(N_CH);
      if (!any_req && (|(req & (N_CH'(1) << pos)))) begin
        any_req    = 1'b1;
        next_grant = pos[2:0];
      end
    end
  end

  always_comb begin
    grant_mask = N_CH'(1) << grant;
    cur_valid  = |(in_valid & grant_mask);
    cur_char   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant == 3'(i)) cur_char = in_char[8*i +: 8];
    end
    is_term = (cur_char == TERM);
  end

  always_comb begin
    in_ready  = (state == STREAM) ? grant_mask : '0;
    chk_en    = (state == STREAM) && cur_valid && !is_term;
    chk_in    = chk_en ? cur_char : '0;
    chk_reset = reset || (state == CLR);
    busy      = (state != IDLE);
  end

`ifdef BLOCK_CHECK_SCHED_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign timed_out = (state == STREAM) && !cur_valid && (idle_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt   <= '0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          idle_cnt   <= '0;
          abort_pend <= 1'b0;
        end
        STREAM: begin
          if (cur_valid) idle_cnt <= '0;
          else           idle_cnt <= idle_cnt + 8'd1;
          if (timed_out) abort_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign timed_out  = 1'b0;
  assign abort_pend = 1'b0;
  assign res_abort  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_chan  <= '0;
      res_ok    <= 1'b0;
`ifdef BLOCK_CHECK_SCHED_TIMEOUT_EN
      res_abort <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (any_req) begin
            grant <= next_grant;
            state <= CLR;
          end
        end
        CLR: state <= STREAM;
        STREAM: begin
          if ((cur_valid && is_term) || timed_out) state <= SETTLE;
        end
        SETTLE: begin
          // Checker verdict is valid one cycle after the last forwarded byte.
          res_ok    <= chk_result && !abort_pend;
          res_chan  <= grant;
          res_valid <= 1'b1;
`ifdef BLOCK_CHECK_SCHED_TIMEOUT_EN
          res_abort <= abort_pend;
`endif
          state     <= REPORT;
        end
        REPORT: begin
          res_valid <= 1'b0;
          rr_ptr    <= (grant == 3'(N_CH - 1)) ? 3'd0 : grant + 3'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_check_sched.sv
// Scoreboard bench for block_check_sched with a behavioural begin/end checker attached.
module tb_block_check_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] in_char;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        chk_reset, chk_en, chk_result;
  logic [7:0]  chk_in;
  logic        busy, res_valid, res_ok, res_abort;
  logic [2:0]  res_chan;

  localparam logic [7:0] TERM_B = 8'h0A;

  always #5 clk = ~clk;

`ifdef BLOCK_CHECK_SCHED_TIMEOUT_EN
  block_check_sched #(.N_CH(4), .TERM(TERM_B), .TIMEOUT(5)) dut (
`else
  block_check_sched #(.N_CH(4), .TERM(TERM_B)) dut (
`endif
    .clk(clk), .reset(reset), .req(req), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .chk_reset(chk_reset), .chk_en(chk_en), .chk_in(chk_in),
    .chk_result(chk_result), .busy(busy), .res_valid(res_valid), .res_chan(res_chan),
    .res_ok(res_ok), .res_abort(res_abort));

  // Nesting checker: "begin" opens, "end" closes; closing at depth 0 is a sticky error.
  int          depth = 0;
  logic        neg = 1'b0;
  logic [39:0] hist = '0;
  logic [39:0] nh;
  always @(posedge clk) begin
    if (chk_reset) begin
      depth <= 0; neg <= 1'b0; hist <= '0;
    end else if (chk_en) begin
      nh = {hist[31:0], chk_in};
      hist <= nh;
      if (nh == "begin") depth <= depth + 1;
      else if (nh[23:0] == "end") begin
        if (depth == 0) neg <= 1'b1;
        else depth <= depth - 1;
      end
    end
  end
  assign chk_result = (depth == 0) && !neg;

  typedef struct {
    logic [2:0] chan;
    logic       ok;
    logic       abort;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks = 0, errors = 0;
  int         cyc = 0, en_cnt = 0, rst_cnt = 0, res_cnt = 0, exp_total = 0, oh_err = 0;
  logic [6:0] en_hist = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] chan, input logic ok, input logic abort, input int c);
    exp_t e;
    e.chan = chan; e.ok = ok; e.abort = abort; e.cyc = c;
    sbq.push_back(e);
    exp_total++;
  endtask

  always @(negedge clk) begin
    if (chk_en) en_cnt++;
    if (chk_reset) rst_cnt++;
    if (in_ready != 4'b0) en_hist = {en_hist[5:0], chk_en};
    if ($countones(in_ready) > 1 || (in_ready != 4'b0 && !busy)) oh_err++;
    if (res_valid) begin
      res_cnt++;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: chan %0d ok %0b, none expected", res_chan, res_ok);
      end else begin
        mon_e = sbq.pop_front();
        check("res_chan", 64'(res_chan), 64'(mon_e.chan));
        check("res_ok", 64'(res_ok), 64'(mon_e.ok));
        check("res_abort", 64'(res_abort), 64'(mon_e.abort));
        if (mon_e.cyc >= 0) check("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (busy && n < 200);
    check("idle_wait", 64'(busy), 64'(0));
  endtask

  task automatic send(input logic [3:0] rq, input logic [3:0] vmask, input string s,
                      input bit term, input bit keep, input int stall_at, input int stall_n);
    int  n = 0;
    byte b;
    req = rq;
    do begin
      @(posedge clk); #1; n++;
    end while ((in_ready & vmask) == 4'b0 && n < 50);
    check("grant_wait", 64'((in_ready & vmask) != 4'b0), 64'(1));
    if (!keep) req = '0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() && !term) break;
      if (i == stall_at) begin
        repeat (stall_n) begin
          in_valid = '0; @(posedge clk); #1;
        end
      end
      b = (i < s.len()) ? s[i] : TERM_B;
      in_char = {4{b}};
      in_valid = vmask;
      @(posedge clk); #1;
    end
    in_valid = '0;
    in_char = '0;
  endtask

  int e0, r0, n0;

  initial begin
    reset = 1'b1; req = '0; in_valid = '0; in_char = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_chk_reset", 64'(chk_reset), 64'(1));
    check("reset_outputs",
          64'({busy, res_valid, res_ok, res_abort, res_chan, in_ready, chk_en, chk_in}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // All four held: service order 0,1,2,3,0.
    push(3'd0, 1'b1, 1'b0, -1); push(3'd1, 1'b1, 1'b0, -1);
    push(3'd2, 1'b1, 1'b0, -1); push(3'd3, 1'b1, 1'b0, -1);
    push(3'd0, 1'b1, 1'b0, -1);
    for (int k = 0; k < 5; k++) send(4'b1111, 4'b1111, "x", 1'b1, (k < 4), -1, 0);

    wait_idle();
    e0 = en_cnt;
    push(3'd0, 1'b1, 1'b0, cyc + 13);
    send(4'b0001, 4'b0001, "begin end", 1'b1, 1'b0, -1, 0);
    wait_idle();
    check("en_count_single", 64'(en_cnt - e0), 64'(9));

    push(3'd2, 1'b0, 1'b0, -1);
    send(4'b0100, 4'b0100, "begin begin end", 1'b1, 1'b0, -1, 0);

    wait_idle();
    push(3'd1, 1'b0, 1'b0, -1);
    send(4'b0010, 4'b0010, "end", 1'b1, 1'b0, 1, 3);
    check("stall_pattern", 64'(en_hist), 64'(7'b1000110));

    wait_idle();
    e0 = en_cnt; r0 = rst_cnt;
    push(3'd3, 1'b1, 1'b0, -1);
    send(4'b1000, 4'b1000, "", 1'b1, 1'b0, -1, 0);
    check("empty_en_count", 64'(en_cnt - e0), 64'(0));
    check("empty_clr_cycles", 64'(rst_cnt - r0), 64'(1));

    wait_idle();
    n0 = res_cnt;
    send(4'b0001, 4'b0001, "beg", 1'b0, 1'b0, -1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_midmsg_idle", 64'(busy), 64'(0));
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_result_after_reset", 64'(res_cnt - n0), 64'(0));

    wait_idle();
    push(3'd0, 1'b1, 1'b0, cyc + 13);
    send(4'b0001, 4'b0001, "begin end", 1'b1, 1'b0, -1, 0);

`ifdef BLOCK_CHECK_SCHED_TIMEOUT_EN
    wait_idle();
    push(3'd2, 1'b0, 1'b1, -1);
    send(4'b0100, 4'b0100, "b", 1'b0, 1'b0, -1, 0);
`endif

    wait_idle();
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));
    check("in_ready_onehot", 64'(oh_err), 64'(0));
    check("result_count", 64'(res_cnt), 64'(exp_total));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_check_sched.md
Name: block_check_sched

Overview:
- Round-robin scheduler that shares one begin/end nesting checker among N_CH character sources.
- Each source sends a newline-terminated message over a valid/ready byte interface.
- The block grants one channel per message, clears the checker, and forwards the message bytes with an enable strobe.
- It then captures the checker verdict and reports it, tagged with the channel, before serving the next requester.

Parameters:
- N_CH, 4: number of requesting channels (2..8).
- TERM, 8'h0A: message terminator byte. It is consumed, never forwarded.
- TIMEOUT, 255: idle-cycle limit within a message. Used only with the optional feature.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_CH  per-channel message request.
- in_char  in  8*N_CH  per-channel byte; channel k occupies bits [8k+7:8k].
- in_valid  in  N_CH  per-channel byte valid.
- in_ready  out  N_CH  per-channel byte ready; at most one bit high.
- chk_reset  out  1  clear pulse to the checker.
- chk_en  out  1  checker samples chk_in only when high.
- chk_in  out  8  byte to the checker.
- chk_result  in  1  checker verdict (1 = balanced), valid the cycle after the last sampled byte.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_chan  out  3  channel the result belongs to.
- res_ok  out  1  captured verdict.
- res_abort  out  1  message aborted by timeout. Tied 0 without the optional feature.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0, res_valid=0, res_chan=0, res_ok=0, res_abort=0, in_ready=0, chk_en=0, chk_in=0.
- chk_reset = reset OR (state==CLR).
- FSM states: IDLE, CLR, STREAM, SETTLE, REPORT.
- IDLE:
  - If any req bit is high, grant = the first set bit searching upward from rr_ptr, wrapping modulo N_CH.
  - Next state is CLR. Otherwise stay in IDLE.
- CLR:
  - Exactly one cycle with chk_reset=1; then STREAM.
- STREAM:
  - in_ready[grant]=1; all other in_ready bits are 0.
  - On in_valid[grant] with a byte != TERM: chk_en=1 and chk_in=byte, combinationally in the same cycle.
  - On in_valid[grant] with a byte == TERM: chk_en=0 and next state is SETTLE.
  - in_valid low stalls the stream: chk_en=0 and chk_in holds 0.
  - The grant is held even if req[grant] drops mid-message.
  - Requests from other channels are ignored until the return to IDLE.
- SETTLE:
  - One cycle; registers chk_result into res_ok. Next state is REPORT.
- REPORT:
  - res_valid=1 for exactly one cycle, with res_chan=grant.
  - rr_ptr = (grant+1) mod N_CH. Next state is IDLE.
- res_chan and res_ok hold their values until the next REPORT.
- Minimum message latency: req seen in IDLE, then 1 CLR, k byte cycles, 1 TERM cycle, 1 SETTLE, 1 REPORT.
  - Total = k+4 cycles after the IDLE cycle.
- Empty message (TERM is the first byte): the checker was just cleared, so res_ok=1.
- Back-to-back: a channel may re-request immediately; rr_ptr prevents it from starving the others.
- Reset in any state returns to IDLE within that edge and holds chk_reset high. No res_valid is produced for an interrupted message.
- in_char of non-granted channels has no effect.
- TERM is never forwarded to the checker.

Optional Feature:
- Macro: BLOCK_CHECK_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter clears on CLR and on every accepted byte, and increments each STREAM cycle without an accepted byte.
  - When the counter reaches TIMEOUT, next state is SETTLE, with a pending abort flag set.
  - REPORT then drives res_ok=0 and res_abort=1.
  - Remaining bytes of that message are later treated as a new message if the channel requests again.
- Undefined:
  - No counter; STREAM waits indefinitely and res_abort is tied 0.

Test Plan:
- Single channel: req[0]=1, stream "begin end\n", checker model attached -> res_valid pulse with res_chan=0, res_ok=1, 4+9 cycles after grant. chk_en is high for exactly 9 cycles.
- Unbalanced message: ch2 sends "begin begin end\n" -> res_ok=0, res_chan=2.
- Contention: req=4'b1111 held, each channel sends "x\n" -> grant order 0,1,2,3,0. Exactly one in_ready bit high in STREAM, none elsewhere.
- Stall: ch1 sends "end" with in_valid low for 3 cycles between 'e' and 'n' -> chk_en pattern 1,0,0,0,1,1. res_ok=0 (count went negative).
- Empty message: ch3 sends "\n" -> res_ok=1. chk_en never high. chk_reset high for exactly one cycle before STREAM.
- Reset mid-message during STREAM after "beg" -> state IDLE next cycle and no res_valid. A subsequent "begin end\n" on ch0 gives res_ok=1. With BLOCK_CHECK_SCHED_TIMEOUT_EN and TIMEOUT=5, 5 idle cycles in STREAM -> res_abort=1, res_ok=0.
